// File: rtl/uart_pkg.sv
// Shared definitions for the host command UART: receiver FSM encoding,
// command byte codes and the line idle level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] CMD_X0 = 8'h78;
  localparam logic [7:0] CMD_Y0 = 8'h79;
  localparam logic [7:0] CMD_Z0 = 8'h7A;
  localparam logic [7:0] CMD_X1 = 8'h58;
  localparam logic [7:0] CMD_Y1 = 8'h59;
  localparam logic [7:0] CMD_Z1 = 8'h5A;

  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags the
// high-to-low transition that marks a candidate start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic rx_s,
  output logic start_det
);

  logic rx_m;
  logic rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= UART_IDLE;
      rx_s <= UART_IDLE;
      rx_d <= UART_IDLE;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // A line held low (break) never retriggers: an edge is required.
  assign start_det = rx_d & ~rx_s;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 command receiver with internal bit timing. Optional 2-of-3 majority
// sampling is enabled by defining UART_CMD_RX_MAJORITY_EN.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;
  logic start_det;
  logic rx_bit;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_s      (rx_s),
    .start_det (start_det)
  );

`ifdef UART_CMD_RX_MAJORITY_EN
  logic rx_h1;
  logic rx_h2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_h1 <= UART_IDLE;
      rx_h2 <= UART_IDLE;
    end else begin
      rx_h1 <= rx_s;
      rx_h2 <= rx_h1;
    end
  end

  // Vote over the sample cycle and the two before it; timing is unchanged.
  assign rx_bit = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
  assign rx_bit = rx_s;
`endif

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data_nxt;
  logic             rx_int_nxt;
  logic             rx_valid_nxt;
  logic             frame_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_data   <= 8'h00;
      rx_int    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      rx_data   <= rx_data_nxt;
      rx_int    <= rx_int_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    rx_data_nxt   = rx_data;
    rx_int_nxt    = rx_int;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_det) state_nxt = START;
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_bit) begin
            rx_int_nxt  = 1'b1;
            bit_idx_nxt = '0;
            state_nxt   = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_bit, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end

      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt == CNT_FULL) begin
          cnt_nxt    = '0;
          state_nxt  = IDLE;
          rx_int_nxt = 1'b0;
          if (rx_bit) begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
          end else begin
            rx_data_nxt   = 8'h00;
            frame_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at 16 clocks per bit: stimulus pushes the
// expected byte/error per frame, a negedge monitor checks each output pulse.
module tb_uart_cmd_rx;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_valid;
  logic       frame_err;

  uart_cmd_rx #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  localparam int BIT_CLKS = 16;
  localparam int INT_WIDTH = 9 * BIT_CLKS;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rst_bit >= 0 pulses reset mid-way through that bit and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit glitch, input int rst_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      if (i == rst_bit) begin
        tick(8);
        chk("rx_int_before_rst", {31'd0, rx_int}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_int", {31'd0, rx_int}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        uart_rx = 1'b1;
        return;
      end else if (glitch && i >= 1 && i <= 8) begin
        tick(8);
        uart_rx = ~bits[i];
        tick(1);
        uart_rx = bits[i];
        tick(7);
      end else begin
        tick(BIT_CLKS);
      end
    end
  endtask

  // Monitor: every rx_valid/frame_err pulse must match the head of the queue.
  int   width     = 0;
  logic prev_int  = 1'b0;
  logic prev_puls = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      chk("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      chk("pulse_one_cycle", {31'd0, prev_puls}, 32'd0);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: rx_valid=%0b frame_err=%0b rx_data=%0h, expected none (t=%0t)",
                 rx_valid, frame_err, rx_data, $time);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, e.err});
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        chk("rx_int_width", width, INT_WIDTH);
        chk("rx_int_fall", {30'd0, prev_int, rx_int}, 32'd2);
      end
    end
    width     = rx_int ? width + 1 : 0;
    prev_int  = rx_int;
    prev_puls = rx_valid | frame_err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  logic seen;

  initial begin
    uart_rx = 1'b1;
    rst     = 1'b1;
    tick(4);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_int", {31'd0, rx_int}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(20);

    // Clean frame
    q.push_back('{err: 1'b0, data: 8'h78});
    send_frame(8'h78, 1'b1, 1'b0, -1);
    tick(40);
    chk("clean_frame_done", q.size(), 0);

    // Back-to-back frames with no idle gap
    q.push_back('{err: 1'b0, data: 8'h5A});
    q.push_back('{err: 1'b0, data: 8'h79});
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    send_frame(8'h79, 1'b1, 1'b0, -1);
    tick(40);
    chk("b2b_frames_done", q.size(), 0);
    chk("rx_data_hold", {24'd0, rx_data}, 32'h79);

    // Framing error followed by a held-low line
    q.push_back('{err: 1'b1, data: 8'h00});
    send_frame(8'h59, 1'b0, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen |= rx_int;
    end
    uart_rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen |= rx_int;
    end
    chk("break_no_retrigger", {31'd0, seen}, 32'd0);
    chk("ferr_frame_done", q.size(), 0);

    // Short low glitch on an idle line
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen |= rx_int;
    end
    chk("glitch_rx_int", {31'd0, seen}, 32'd0);
    chk("glitch_rx_data_hold", {24'd0, rx_data}, 32'h00);

    // Reset during data bit 4, then a normal frame
    send_frame(8'h7A, 1'b1, 1'b0, 5);
    tick(60);
    q.push_back('{err: 1'b0, data: 8'h58});
    send_frame(8'h58, 1'b1, 1'b0, -1);
    tick(40);
    chk("after_reset_frame_done", q.size(), 0);

    // One-cycle inverted glitch at each data bit centre
`ifdef UART_CMD_RX_MAJORITY_EN
    q.push_back('{err: 1'b0, data: 8'h78});
`else
    q.push_back('{err: 1'b0, data: 8'h87});
`endif
    send_frame(8'h78, 1'b1, 1'b1, -1);
    tick(40);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receiver for the host-to-board command channel. It deserialises 8N1 frames from the USB-UART bridge line into `rx_data`, and frames each byte with `rx_int`. The downstream `uart_tx` latches `rx_data` on the falling edge of `rx_int` and answers with the requested ADXL345 axis byte. The block generates its own bit timing, so it needs no external baud-rate module.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived localparams:
  - `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division).
  - `HALF_BIT = CLKS_PER_BIT/2`.
  - `CLKS_PER_BIT` must be ≥ 8.

Ports:
- `clk`  in  1: system clock, the only clock. All logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `uart_rx`  in  1: asynchronous serial input; idles high.
- `rx_data`  out  8: last received byte. Reset 8'h00.
- `rx_int`  out  1: high while a validated frame is being received. Reset 0.
- `rx_valid`  out  1: one-cycle pulse when a good byte is loaded into `rx_data`. Reset 0.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low. Reset 0.

## Operation
- **Input synchroniser:** `uart_rx` passes through 2 flops to give `rx_s`, plus 1 delay flop to give `rx_d`. All three reset to 1.
- **Start detect:** `rx_d==1 && rx_s==0`.
- **Bit counter `cnt`:** counts clk cycles from 0 and clears on every state transition and after every sample.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: on start detect, go to START.
  - START: sample at `cnt==HALF_BIT-1`.
    - Sample 0: set `rx_int<=1` and go to DATA with `bit_idx=0`.
    - Sample 1 (glitch): return to IDLE; `rx_int` never rises.
  - DATA: sample at `cnt==CLKS_PER_BIT-1`.
    - Shift the sample in LSB first: `shreg <= {sample, shreg[7:1]}`.
    - After `bit_idx==7`, go to STOP.
  - STOP: sample at `cnt==CLKS_PER_BIT-1`, then always go to IDLE and set `rx_int<=0`.
    - Sample 1: `rx_data<=shreg` and pulse `rx_valid`.
    - Sample 0: `rx_data<=8'h00` and pulse `frame_err`. This makes `uart_tx` reply 0x00 through its default case.
- **Line held low after a framing error (break):** no retrigger, because start detect needs a high-to-low transition.
- **Back-to-back frames:** FSM returns to IDLE at mid-stop-bit, so a start edge at the end of the stop bit is caught.
- **`rx_data` hold:** `rx_data` holds its value from the end of one frame to the end of the next. It is stable whenever `rx_int` falls.
- **Reset mid-frame:** the FSM goes to IDLE, all outputs take their reset values, and no `rx_valid` or `frame_err` pulse is produced.

## Timing
- Entering START to start-bit sample: HALF_BIT cycles. `rx_int` is high from the next cycle.
- Entering START to the STOP sample: `HALF_BIT + 9*CLKS_PER_BIT` cycles. `rx_data`, `rx_valid`/`frame_err` and the fall of `rx_int` all update on the cycle after the STOP sample.
- Input pin to start detect: 3 clk cycles.
- Each data sample falls within ±1 clk of the nominal bit centre.
- `rx_valid` and `frame_err` are mutually exclusive and each lasts exactly 1 cycle.

## Configuration
- `UART_CMD_RX_MAJORITY_EN` defined:
  - Each start, data and stop decision is the 2-of-3 majority of `rx_s` over the three cycles ending at the sample cycle.
  - Sample timing is unchanged.
- Undefined: each decision is the single `rx_s` value at the sample cycle.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Command code constants: CMD_X0=8'h78, CMD_Y0=8'h79, CMD_Z0=8'h7A, CMD_X1=8'h58, CMD_Y1=8'h59, CMD_Z1=8'h5A.
  - Line idle level `UART_IDLE=1'b1`.
- One sub-module, `uart_rx_sync`, holds the 2-flop synchroniser, the delay flop and start detect. Outputs: `rx_s`, `start_det`.
- The FSM, counters and shift register stay in the top module.

## Test plan
All scenarios use `CLK_FREQ=160`, `BAUD=10`, giving `CLKS_PER_BIT=16`.
- Send 8'h78 as a clean 8N1 frame.
  - `rx_int` is high for 144 cycles.
  - `rx_data=8'h78` and a single `rx_valid` pulse, both on the cycle `rx_int` falls.
  - `frame_err` stays 0.
- Send 8'h5A immediately followed by 8'h79 (no idle gap) → two `rx_valid` pulses, `rx_data` 8'h5A then 8'h79.
- Send 8'h59 with its stop bit forced low → `frame_err` pulse, `rx_data=8'h00`, `rx_valid` stays 0.
  - Then hold the line low for 40 cycles → no new frame starts.
- Drive a 4-cycle low glitch on an idle line → FSM returns to IDLE; `rx_int`, `rx_valid` and `frame_err` all stay 0.
- Assert `rst` for 1 cycle during data bit 4 of 8'h7A.
  - The next cycle has all outputs at reset values and no pulses.
  - A following 8'h58 is received correctly.
- With `UART_CMD_RX_MAJORITY_EN` defined, send 8'h78 with a 1-cycle inverted glitch at the centre of each data bit → `rx_data=8'h78`.
  - Without the macro, the same stimulus yields 8'h87.
